// File: rtl/bram_tdp_be.sv
// True-dual-port byte-enable RAM, one clock, with post-reset clear sequencer and collision flag.
// Latency: dout/valid 1+OUT_REG edges after acceptance; collision 1 edge; clear takes 2**ADDR cycles.
// Backpressure: none; both ports accept one access per cycle, but accesses are ignored while init_busy.
module bram_tdp_be #(
  parameter int              DATA       = 32,
  parameter int              ADDR       = 10,
  parameter int              OUT_REG    = 0,
  parameter int              RDW_MODE   = 0,
  parameter logic [DATA-1:0] INIT_VALUE = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                init_busy,
  input  logic                a_en,
  input  logic [DATA/8-1:0]   a_we,
  input  logic [ADDR-1:0]     a_addr,
  input  logic [DATA-1:0]     a_din,
  output logic [DATA-1:0]     a_dout,
  output logic                a_valid,
  input  logic                b_en,
  input  logic [DATA/8-1:0]   b_we,
  input  logic [ADDR-1:0]     b_addr,
  input  logic [DATA-1:0]     b_din,
  output logic [DATA-1:0]     b_dout,
  output logic                b_valid,
  output logic                collision
);

  localparam int LANES = DATA / 8;
  localparam int DEPTH = 2 ** ADDR;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [ADDR-1:0] ptr, ptr_nxt;
  logic            clr_we;

  logic [DATA-1:0] mem [DEPTH];

  logic            a_acc, a_wr, b_acc, b_wr;
  logic [DATA-1:0] a_old, b_old, a_rd_nxt, b_rd_nxt;
  logic [DATA-1:0] a_d1, b_d1;
  logic            a_v1, b_v1;
  logic            col_q;

  // Accesses count only in RUN and never in a reset cycle.
  assign a_acc = a_en & (state == RUN) & ~rst;
  assign b_acc = b_en & (state == RUN) & ~rst;
  assign a_wr  = a_acc & (|a_we);
  assign b_wr  = b_acc & (|b_we);

  assign init_busy = (state == CLEAR);
  assign collision = col_q;

  // Sequencer state and clear pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Clear walks every address once, then hands the array over to the ports.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = ~rst;
        ptr_nxt = ptr + ADDR'(1);
        if (&ptr) state_nxt = RUN;
      end
      RUN: ;
      default: state_nxt = CLEAR;
    endcase
  end

  // Array writes; B's lane writes come last so B wins overlapping lanes on a shared address.
  always_ff @(posedge clk) begin
    if (clr_we) mem[ptr] <= INIT_VALUE;
    for (int i = 0; i < LANES; i++) begin
      if (a_wr && a_we[i]) mem[a_addr][i*8 +: 8] <= a_din[i*8 +: 8];
      if (b_wr && b_we[i]) mem[b_addr][i*8 +: 8] <= b_din[i*8 +: 8];
    end
  end

  // Read data: a writer sees only its own bytes (write-first) or the old word (read-first);
  // a reader always sees the pre-write word, which resolves read/write collisions.
  always_comb begin
    a_old    = mem[a_addr];
    b_old    = mem[b_addr];
    a_rd_nxt = a_old;
    b_rd_nxt = b_old;
    if (RDW_MODE == 0) begin
      for (int i = 0; i < LANES; i++) begin
        if (a_wr && a_we[i]) a_rd_nxt[i*8 +: 8] = a_din[i*8 +: 8];
        if (b_wr && b_we[i]) b_rd_nxt[i*8 +: 8] = b_din[i*8 +: 8];
      end
    end
  end

  // First output stage: data holds when idle, valid pulses per accepted access.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_d1 <= '0;
      b_d1 <= '0;
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      if (a_acc) a_d1 <= a_rd_nxt;
      if (b_acc) b_d1 <= b_rd_nxt;
    end
  end

  // Same-address conflict flag, registered once independent of the output pipeline depth.
  always_ff @(posedge clk) begin
    if (rst) col_q <= 1'b0;
    else     col_q <= a_acc & b_acc & (a_addr == b_addr) & (a_wr | b_wr);
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA-1:0] a_d2, b_d2;
      logic            a_v2, b_v2;

      // Optional second stage; data and valid move together.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_d2 <= '0;
          b_d2 <= '0;
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
        end else begin
          a_d2 <= a_d1;
          b_d2 <= b_d1;
          a_v2 <= a_v1;
          b_v2 <= b_v1;
        end
      end

      assign a_dout  = a_d2;
      assign b_dout  = b_d2;
      assign a_valid = a_v2;
      assign b_valid = b_v2;
    end else begin : g_noreg
      assign a_dout  = a_d1;
      assign b_dout  = b_d1;
      assign a_valid = a_v1;
      assign b_valid = b_v1;
    end
  endgenerate

endmodule

// File: tb/tb_bram_tdp_be.sv
module tb_bram_tdp_be;

  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_en = 1'b0, b_en = 1'b0;
  logic [3:0]  a_we = '0, b_we = '0;
  logic [3:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_din = '0, b_din = '0;

  // w_: write-first, latency 1; r_: read-first, latency 1; p_: write-first, latency 2
  logic        w_busy, r_busy, p_busy;
  logic [31:0] w_a_dout, w_b_dout, r_a_dout, r_b_dout, p_a_dout, p_b_dout;
  logic        w_a_valid, w_b_valid, r_a_valid, r_b_valid, p_a_valid, p_b_valid;
  logic        w_col, r_col, p_col;

  int passed = 0;
  int total  = 0;
  int cnt;
  int pv;
  logic saw_valid;

  always #5 clk = ~clk;

  bram_tdp_be #(.DATA(32), .ADDR(4), .OUT_REG(0), .RDW_MODE(0), .INIT_VALUE(INIT)) u_w (
    .clk(clk), .rst(rst), .init_busy(w_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(w_a_dout), .a_valid(w_a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(w_b_dout), .b_valid(w_b_valid),
    .collision(w_col));

  bram_tdp_be #(.DATA(32), .ADDR(4), .OUT_REG(0), .RDW_MODE(1), .INIT_VALUE(INIT)) u_r (
    .clk(clk), .rst(rst), .init_busy(r_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(r_a_dout), .a_valid(r_a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(r_b_dout), .b_valid(r_b_valid),
    .collision(r_col));

  bram_tdp_be #(.DATA(32), .ADDR(4), .OUT_REG(1), .RDW_MODE(0), .INIT_VALUE(INIT)) u_p (
    .clk(clk), .rst(rst), .init_busy(p_busy),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(p_a_dout), .a_valid(p_a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(p_b_dout), .b_valid(p_b_valid),
    .collision(p_col));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_busy",    32'(w_busy), 32'd1);
    check("rst_a_dout",  w_a_dout, 32'h0);
    check("rst_a_valid", 32'(w_a_valid), 32'd0);
    check("rst_col",     32'(w_col), 32'd0);
    check("rst_p_dout",  p_a_dout, 32'h0);
    check("rst_p_valid", 32'(p_a_valid), 32'd0);

    // Start a clear, interrupt it at pointer 9, then time the restarted clear
    rst = 1'b0;
    repeat (9) tick();
    check("midclear_busy", 32'(w_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_we = 4'hF; a_addr = 4'd0; a_din = 32'h12345678;
    cnt = 0;
    saw_valid = 1'b0;
    while (w_busy && cnt < 40) begin
      tick();
      cnt++;
      a_en = (cnt == 4);
      if (w_a_valid || p_a_valid) saw_valid = 1'b1;
    end
    a_en = 1'b0;
    check("clear_cycles",    32'(cnt), 32'd16);
    check("clear_p_busy",    32'(p_busy), 32'd0);
    check("clear_no_valid",  32'(saw_valid), 32'd0);
    check("clear_dout_hold", w_a_dout, 32'h0);

    // Back-to-back reads of the whole array; p_ stream appears one cycle later
    a_we = 4'h0;
    pv = 0;
    for (int i = 0; i < 16; i++) begin
      a_en = 1'b1;
      a_addr = 4'(i);
      tick();
      check("init_rd",   w_a_dout, INIT);
      check("init_vld",  32'(w_a_valid), 32'd1);
      if (i == 0) check("p_lat2", 32'(p_a_valid), 32'd0);
      if (p_a_valid) pv++;
    end
    a_en = 1'b0;
    tick();
    check("idle_vld",  32'(w_a_valid), 32'd0);
    check("p_last_rd", p_a_dout, INIT);
    if (p_a_valid) pv++;
    tick();
    check("p_vld_end", 32'(p_a_valid), 32'd0);
    if (p_a_valid) pv++;
    check("p_stream_cnt", 32'(pv), 32'd16);

    // Byte lanes: write lanes 0 and 2 of address 3
    a_en = 1'b1; a_we = 4'b0101; a_addr = 4'd3; a_din = 32'h11223344;
    tick();
    check("be_wf_dout", w_a_dout, 32'hA522A544);
    check("be_rf_dout", r_a_dout, INIT);
    a_en = 1'b0; a_we = 4'h0;
    b_en = 1'b1; b_we = 4'h0; b_addr = 4'd3;
    tick();
    check("be_b_rd",  w_b_dout, 32'hA522A544);
    check("be_b_vld", 32'(w_b_valid), 32'd1);
    b_en = 1'b0;

    // Read-during-write modes at address 5
    a_en = 1'b1; a_we = 4'hF; a_addr = 4'd5; a_din = 32'h0;
    tick();
    a_din = 32'hDEADBEEF;
    tick();
    check("rdw_wf", w_a_dout, 32'hDEADBEEF);
    check("rdw_rf", r_a_dout, 32'h0);
    a_we = 4'h0;
    tick();
    check("wr_rd_wf", w_a_dout, 32'hDEADBEEF);
    check("wr_rd_rf", r_a_dout, 32'hDEADBEEF);

    // Write/write collision at address 7
    a_we = 4'b0011; a_addr = 4'd7; a_din = 32'h000000FF;
    b_en = 1'b1; b_we = 4'b0110; b_addr = 4'd7; b_din = 32'hAABB0000;
    tick();
    check("ww_col",    32'(w_col), 32'd1);
    check("ww_p_col",  32'(p_col), 32'd1);
    check("ww_a_dout", w_a_dout, 32'hA5A500FF);
    check("ww_b_dout", w_b_dout, 32'hA5BB00A5);
    b_en = 1'b0; b_we = 4'h0;
    a_we = 4'h0;
    tick();
    check("ww_mem",    w_a_dout, 32'hA5BB00FF);
    check("ww_pulse",  32'(w_col), 32'd0);

    // Read/write collision at address 2, then same-address reads
    a_we = 4'hF; a_addr = 4'd2; a_din = 32'h5;
    tick();
    a_din = 32'h9;
    b_en = 1'b1; b_addr = 4'd2;
    tick();
    check("rw_b_old",  w_b_dout, 32'h5);
    check("rw_rf_b",   r_b_dout, 32'h5);
    check("rw_col",    32'(w_col), 32'd1);
    check("rw_wf_a",   w_a_dout, 32'h9);
    check("rw_rf_a",   r_a_dout, 32'h5);
    a_we = 4'h0;
    tick();
    check("rr_nocol",  32'(w_col), 32'd0);
    check("rr_a",      w_a_dout, 32'h9);
    check("rr_b",      w_b_dout, 32'h9);
    a_en = 1'b0; b_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bram_tdp_be.md
# bram_tdp_be

Parametrised true-dual-port block RAM on one clock, successor to the team's basic TDP RAM. Adds per-port byte-lane write enables, a selectable read-during-write mode, an optional output pipeline register with a valid strobe, a hardware clear sequencer after reset, and same-address collision detection with deterministic resolution. It is intended for MSI-X vector table and PBA storage, where one port serves the PCIe TLP side and the other serves the interrupt engine.

## Interface
Parameters:
- DATA, 32: word width in bits; must be a multiple of 8.
- ADDR, 10: address width; depth is 2**ADDR words.
- OUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- RDW_MODE, 0: same-port read-during-write; 0 = write-first, 1 = read-first.
- INIT_VALUE, 0: DATA-bit value written to every word by the clear sequencer.

Ports (clock and reset first):
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the clear sequencer runs; ports are ignored while it is high.
- a_en  in  1  port A access enable.
- a_we  in  DATA/8  port A byte-lane write enables; any bit set makes the access a write.
- a_addr  in  ADDR  port A word address.
- a_din  in  DATA  port A write data.
- a_dout  out  DATA  port A read data.
- a_valid  out  1  port A access result strobe, one cycle wide.
- b_en, b_we, b_addr, b_din, b_dout, b_valid: same as port A, for port B.
- collision  out  1  one-cycle pulse flagging a same-address conflict.

## Operation
- FSM has two states: CLEAR and RUN.
- rst high: state goes to CLEAR, clear pointer goes to 0, and all pipeline and valid registers are zeroed.
- CLEAR, rst low: each cycle writes INIT_VALUE to mem[ptr] and increments ptr. After writing word 2**ADDR-1, the FSM goes to RUN.
- rst asserted mid-clear restarts the clear at address 0.
- Access acceptance: an access is accepted only when x_en=1 in RUN. In CLEAR, enables are ignored: no write, no valid, and dout holds its value.
- Accepted read (x_we=0): dout = mem[addr].
- Accepted write: only lanes with x_we[i]=1 are updated.
  - RDW_MODE=0: dout shows new bytes in written lanes and stored bytes in the others.
  - RDW_MODE=1: dout shows the pre-write word.
- x_valid pulses for every accepted access, reads and writes alike.
- x_dout holds its last value when there is no access.
- Collision: both ports accepted, a_addr==b_addr, and at least one port writing.
  - Both writing: overlapping lanes take B's data (B wins); non-overlapping lanes take their own port's data.
  - One reads while the other writes: the reading port returns the pre-write word.
  - A write port's own dout follows RDW_MODE and ignores the other port's bytes.
- collision is registered and pulses one cycle after the conflicting access. Two reads to the same address are not a collision.
- Reset values: a_dout=b_dout=0, a_valid=b_valid=0, collision=0, init_busy=1.

## Timing
- Clear duration: exactly 2**ADDR cycles from the first cycle with rst low. init_busy falls on the edge after the last clear write, so an access may be presented on that cycle.
- Read and write latency: x_dout and x_valid update 1+OUT_REG edges after the accepting edge.
- Fully pipelined: one accepted access per port per cycle, with no stall.
- With OUT_REG=1, dout and valid advance together, and the pipeline is zeroed by rst.
- collision latency is 1 edge, regardless of OUT_REG.
- Back-to-back write then read of the same address on the same port returns the new data on the read's result cycle. This holds across ports as well, provided the accesses are in different cycles.

## Test plan
Configuration for all scenarios: DATA=32, ADDR=4, INIT_VALUE=32'hA5A5A5A5.
- Reset and clear: hold rst for 3 cycles, then release. Required: init_busy=1 for exactly 16 cycles. Reads of addresses 0..15 then return A5A5A5A5. An access attempted during CLEAR gives no valid and no write.
- Byte lanes: A writes 32'h11223344 with we=4'b0101 to address 3, then B reads address 3. Required: B returns A522A544.
- RDW modes: at address 5 holding 0, port A writes 32'hDEADBEEF with we=F.
  - RDW_MODE=0: a_dout=DEADBEEF.
  - RDW_MODE=1: a_dout=0.
- Collision write/write: same cycle at address 7, A writes 32'h000000FF with we=4'b0011 and B writes 32'hAABB0000 with we=4'b0110. Required: mem[7]=A5BB00FF, and collision pulses one cycle later.
- Collision read/write, plus a no-collision check: at address 2 holding 0x5, B reads while A writes 0x9. Required: b_dout=0x5 and collision=1. Two reads of the same address give collision=0.
- OUT_REG=1 streaming plus reset mid-clear: 16 back-to-back reads return results at latency 2, with valid continuous. rst asserted at clear pointer 9 restarts the clear, and init_busy lasts a full 16 cycles after release.
